// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - CP0 register numbers, bit positions, exception codes and FSM states
package cp0_pkg;

  localparam logic [4:0]  CP0_REG_STATUS = 5'd12;
  localparam logic [4:0]  CP0_REG_CAUSE  = 5'd13;
  localparam logic [4:0]  CP0_REG_EPC    = 5'd14;
  localparam logic [5:0]  CP0_SEL_0      = 6'd0;

  localparam int          STATUS_IE_BIT  = 0;
  localparam int          STATUS_EXL_BIT = 1;

  localparam logic [4:0]  EXC_CODE_INT   = 5'h00;
  localparam logic [31:0] EXC_VECTOR     = 32'hBFC0_0380;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_EPC,
    ST_W_CAUSE,
    ST_W_STATUS,
    ST_JUMP,
    ST_ERET
  } cp0_state_e;

  // Cause layout: BD at 31, IP[15:10], ExcCode at [6:2]
  function automatic logic [31:0] cause_value(input logic bd, input logic [5:0] ip,
                                              input logic [4:0] code);
    cause_value = {bd, 15'b0, ip, 3'b0, code, 2'b00};
  endfunction

endpackage

// File: rtl/cp0_exc_ctrl.sv
// rtl/cp0_exc_ctrl.sv - CP0 exception/ERET/MTC0 write sequencer
// Optional hardware interrupt entry is enabled by defining CP0_INT_EN.
module cp0_exc_ctrl
  import cp0_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        excReq,
  input  logic [4:0]  excCode,
  input  logic [31:0] excPc,
  input  logic        excBd,
  input  logic        eretReq,
  input  logic        mtc0Req,
  input  logic [4:0]  mtc0Addr,
  input  logic [5:0]  mtc0Sel,
  input  logic [31:0] mtc0Data,
  input  logic [31:0] statusIn,
  input  logic [31:0] epcIn,
`ifdef CP0_INT_EN
  input  logic [5:0]  intPending,
`endif
  output logic        cp0Write,
  output logic [4:0]  addrW,
  output logic [5:0]  selW,
  output logic [31:0] din,
  output logic        busy,
  output logic        redirect,
  output logic [31:0] redirectPc
);

  cp0_state_e  state_q, state_d;
  logic [4:0]  code_q, code_d;
  logic [31:0] pc_q, pc_d;
  logic        bd_q, bd_d;
  logic [5:0]  ip_q, ip_d;

  logic        int_take;
  logic [5:0]  ip_src;

`ifdef CP0_INT_EN
  assign ip_src   = intPending;
  assign int_take = statusIn[STATUS_IE_BIT] & ~statusIn[STATUS_EXL_BIT]
                    & (|(intPending & statusIn[15:10]));
`else
  assign ip_src   = 6'b0;
  assign int_take = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      code_q  <= '0;
      pc_q    <= '0;
      bd_q    <= 1'b0;
      ip_q    <= '0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      pc_q    <= pc_d;
      bd_q    <= bd_d;
      ip_q    <= ip_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    code_d     = code_q;
    pc_d       = pc_q;
    bd_d       = bd_q;
    ip_d       = ip_q;
    cp0Write   = 1'b0;
    addrW      = '0;
    selW       = '0;
    din        = '0;
    busy       = 1'b1;
    redirect   = 1'b0;
    redirectPc = '0;

    case (state_q)
      ST_IDLE: begin
        busy = 1'b0;
        if (excReq) begin
          code_d  = excCode;
          pc_d    = excPc;
          bd_d    = excBd;
          ip_d    = ip_src;
          // With EXL already set the original EPC must survive
          state_d = statusIn[STATUS_EXL_BIT] ? ST_W_CAUSE : ST_W_EPC;
        end else if (int_take) begin
          code_d  = EXC_CODE_INT;
          pc_d    = excPc;
          bd_d    = excBd;
          ip_d    = ip_src;
          state_d = ST_W_EPC;
        end else if (eretReq) begin
          state_d = ST_ERET;
        end else if (mtc0Req && !rst) begin
          cp0Write = 1'b1;
          addrW    = mtc0Addr;
          selW     = mtc0Sel;
          din      = mtc0Data;
        end
      end
      ST_W_EPC: begin
        cp0Write = 1'b1;
        addrW    = CP0_REG_EPC;
        selW     = CP0_SEL_0;
        din      = bd_q ? (pc_q - 32'd4) : pc_q;
        state_d  = ST_W_CAUSE;
      end
      ST_W_CAUSE: begin
        cp0Write = 1'b1;
        addrW    = CP0_REG_CAUSE;
        selW     = CP0_SEL_0;
        din      = cause_value(bd_q, ip_q, code_q);
        state_d  = ST_W_STATUS;
      end
      ST_W_STATUS: begin
        cp0Write = 1'b1;
        addrW    = CP0_REG_STATUS;
        selW     = CP0_SEL_0;
        din      = statusIn | 32'h2;
        state_d  = ST_JUMP;
      end
      ST_JUMP: begin
        redirect   = 1'b1;
        redirectPc = EXC_VECTOR;
        state_d    = ST_IDLE;
      end
      ST_ERET: begin
        cp0Write   = 1'b1;
        addrW      = CP0_REG_STATUS;
        selW       = CP0_SEL_0;
        din        = statusIn & ~32'h2;
        redirect   = 1'b1;
        redirectPc = epcIn;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// tb/tb_cp0_exc_ctrl.sv - scoreboard bench for cp0_exc_ctrl
module tb_cp0_exc_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        excReq;
  logic [4:0]  excCode;
  logic [31:0] excPc;
  logic        excBd;
  logic        eretReq;
  logic        mtc0Req;
  logic [4:0]  mtc0Addr;
  logic [5:0]  mtc0Sel;
  logic [31:0] mtc0Data;
  logic [31:0] statusIn;
  logic [31:0] epcIn;
`ifdef CP0_INT_EN
  logic [5:0]  intPending;
`endif
  logic        cp0Write;
  logic [4:0]  addrW;
  logic [5:0]  selW;
  logic [31:0] din;
  logic        busy;
  logic        redirect;
  logic [31:0] redirectPc;

  cp0_exc_ctrl dut (
    .clk(clk), .rst(rst),
    .excReq(excReq), .excCode(excCode), .excPc(excPc), .excBd(excBd),
    .eretReq(eretReq),
    .mtc0Req(mtc0Req), .mtc0Addr(mtc0Addr), .mtc0Sel(mtc0Sel), .mtc0Data(mtc0Data),
    .statusIn(statusIn), .epcIn(epcIn),
`ifdef CP0_INT_EN
    .intPending(intPending),
`endif
    .cp0Write(cp0Write), .addrW(addrW), .selW(selW), .din(din),
    .busy(busy), .redirect(redirect), .redirectPc(redirectPc)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_pass = 0;
  int n_total = 0;

  typedef struct {
    int          c;
    logic        w;
    logic [4:0]  a;
    logic [5:0]  s;
    logic [31:0] d;
    logic        r;
    logic [31:0] pc;
  } ev_t;

  ev_t q[$];

  function automatic void push_ev(input int c, input logic w, input logic [4:0] a,
                                  input logic [5:0] s, input logic [31:0] d,
                                  input logic r, input logic [31:0] pc);
    ev_t e;
    e.c = c; e.w = w; e.a = a; e.s = s; e.d = d; e.r = r; e.pc = pc;
    q.push_back(e);
  endfunction

  // Every write strobe or redirect pulse must match the next expected event, cycle included
  always @(negedge clk) begin
    if (cp0Write || redirect) begin
      ev_t e;
      n_total++;
      if (q.size() == 0) begin
        $display("FAIL unexpected_event: cyc=%0d w=%b a=%0d s=%0d d=%h r=%b pc=%h (expected none)",
                 cyc, cp0Write, addrW, selW, din, redirect, redirectPc);
      end else begin
        e = q.pop_front();
        if ({cyc, cp0Write, addrW, selW, din, redirect, redirectPc} !==
            {e.c, e.w, e.a, e.s, e.d, e.r, e.pc})
          $display("FAIL event: got cyc=%0d w=%b a=%0d s=%0d d=%h r=%b pc=%h, want cyc=%0d w=%b a=%0d s=%0d d=%h r=%b pc=%h",
                   cyc, cp0Write, addrW, selW, din, redirect, redirectPc,
                   e.c, e.w, e.a, e.s, e.d, e.r, e.pc);
        else
          n_pass++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic clear_inputs;
    excReq = 0; excCode = 0; excPc = 0; excBd = 0; eretReq = 0;
    mtc0Req = 0; mtc0Addr = 0; mtc0Sel = 0; mtc0Data = 0;
    statusIn = 0; epcIn = 0;
`ifdef CP0_INT_EN
    intPending = 0;
`endif
  endtask

  task automatic wait_idle(output bit ok);
    ok = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (!busy) begin
        ok = 1;
        break;
      end
    end
  endtask

  task automatic start_exc(input logic [4:0] code, input logic [31:0] pc, input logic bd,
                           input logic [31:0] st, output int c);
    @(posedge clk); #1;
    c = cyc;
    statusIn = st; excCode = code; excPc = pc; excBd = bd; excReq = 1;
  endtask

  task automatic settle_and_check_empty(input string name);
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (q.size() !== 0)
      $display("FAIL %s_pending: %0d expected events never seen, want 0", name, q.size());
    else
      n_pass++;
  endtask

  task automatic test_reset;
    clear_inputs();
    rst = 1;
    mtc0Req = 1; mtc0Addr = 5'd7; mtc0Sel = 6'd3; mtc0Data = 32'hffff_ffff;
    repeat (2) @(negedge clk);
    n_total++;
    if ({cp0Write, busy, redirect, addrW, selW, din, redirectPc} !== '0)
      $display("FAIL reset_outputs: got w=%b busy=%b r=%b a=%0d s=%0d d=%h pc=%h, want all 0",
               cp0Write, busy, redirect, addrW, selW, din, redirectPc);
    else
      n_pass++;
    mtc0Req = 0;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic test_exc_noexl;
    int c; bit ok;
    start_exc(5'h04, 32'h0040_0010, 1'b0, 32'h0000_0401, c);
    push_ev(c + 1, 1, 5'd14, 6'd0, 32'h0040_0010, 0, 32'h0);
    push_ev(c + 2, 1, 5'd13, 6'd0, 32'h0000_0010, 0, 32'h0);
    push_ev(c + 3, 1, 5'd12, 6'd0, 32'h0000_0403, 0, 32'h0);
    push_ev(c + 4, 0, 5'd0,  6'd0, 32'h0,         1, 32'hBFC0_0380);
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL noexl_busy: got %b want 1", busy);
    else n_pass++;
    excCode = 5'h1f; excPc = 32'hdead_beef; excBd = 1;
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL noexl_timeout: busy never fell, got %b want 1", ok);
    else n_pass++;
    excReq = 0;
    settle_and_check_empty("noexl");
  endtask

  task automatic test_exc_bd;
    int c; bit ok;
    start_exc(5'h04, 32'h0040_0010, 1'b1, 32'h0000_ff01, c);
    push_ev(c + 1, 1, 5'd14, 6'd0, 32'h0040_000C, 0, 32'h0);
    push_ev(c + 2, 1, 5'd13, 6'd0, 32'h8000_0010, 0, 32'h0);
    push_ev(c + 3, 1, 5'd12, 6'd0, 32'h0000_ff03, 0, 32'h0);
    push_ev(c + 4, 0, 5'd0,  6'd0, 32'h0,         1, 32'hBFC0_0380);
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL bd_timeout: got %b want 1", ok);
    else n_pass++;
    excReq = 0;
    settle_and_check_empty("bd");
  endtask

  task automatic test_exc_exl;
    int c; bit ok;
    start_exc(5'h0a, 32'h0040_0200, 1'b0, 32'h0000_0002, c);
    push_ev(c + 1, 1, 5'd13, 6'd0, 32'h0000_0028, 0, 32'h0);
    push_ev(c + 2, 1, 5'd12, 6'd0, 32'h0000_0002, 0, 32'h0);
    push_ev(c + 3, 0, 5'd0,  6'd0, 32'h0,         1, 32'hBFC0_0380);
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL exl_timeout: got %b want 1", ok);
    else n_pass++;
    excReq = 0;
    settle_and_check_empty("exl");
  endtask

  task automatic test_eret;
    int c; bit ok;
    @(posedge clk); #1;
    c = cyc;
    statusIn = 32'h3; epcIn = 32'h1234_5678; eretReq = 1;
    push_ev(c + 1, 1, 5'd12, 6'd0, 32'h0000_0001, 1, 32'h1234_5678);
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL eret_busy: got %b want 1", busy);
    else n_pass++;
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL eret_timeout: got %b want 1", ok);
    else n_pass++;
    eretReq = 0;
    settle_and_check_empty("eret");
  endtask

  task automatic test_mtc0;
    int c;
    @(posedge clk); #1;
    c = cyc;
    mtc0Req = 1; mtc0Addr = 5'd9; mtc0Sel = 6'd2; mtc0Data = 32'h0bad_f00d;
    push_ev(c, 1, 5'd9, 6'd2, 32'h0bad_f00d, 0, 32'h0);
    n_total++;
    if (busy !== 1'b0) $display("FAIL mtc0_busy: got %b want 0", busy);
    else n_pass++;
    @(posedge clk); #1;
    mtc0Req = 0;
    settle_and_check_empty("mtc0");
  endtask

  task automatic test_mtc0_vs_exc;
    int c; bit ok;
    start_exc(5'h08, 32'h0040_0100, 1'b0, 32'h0000_0000, c);
    mtc0Req = 1; mtc0Addr = 5'd8; mtc0Sel = 6'd1; mtc0Data = 32'h8765_4321;
    push_ev(c + 1, 1, 5'd14, 6'd0, 32'h0040_0100, 0, 32'h0);
    push_ev(c + 2, 1, 5'd13, 6'd0, 32'h0000_0020, 0, 32'h0);
    push_ev(c + 3, 1, 5'd12, 6'd0, 32'h0000_0002, 0, 32'h0);
    push_ev(c + 4, 0, 5'd0,  6'd0, 32'h0,         1, 32'hBFC0_0380);
    @(posedge clk); #1;
    n_total++;
    if (busy !== 1'b1) $display("FAIL prio_busy: got %b want 1", busy);
    else n_pass++;
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL prio_timeout: got %b want 1", ok);
    else n_pass++;
    excReq = 0;
    push_ev(cyc, 1, 5'd8, 6'd1, 32'h8765_4321, 0, 32'h0);
    @(posedge clk); #1;
    mtc0Req = 0;
    settle_and_check_empty("prio");
  endtask

  task automatic test_back_to_back;
    int c; bit ok;
    start_exc(5'h0d, 32'h0000_0000, 1'b1, 32'h0000_0000, c);
    push_ev(c + 1, 1, 5'd14, 6'd0, 32'hFFFF_FFFC, 0, 32'h0);
    push_ev(c + 2, 1, 5'd13, 6'd0, 32'h8000_0034, 0, 32'h0);
    push_ev(c + 3, 1, 5'd12, 6'd0, 32'h0000_0002, 0, 32'h0);
    push_ev(c + 4, 0, 5'd0,  6'd0, 32'h0,         1, 32'hBFC0_0380);
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL b2b_exc_timeout: got %b want 1", ok);
    else n_pass++;
    excReq = 0;
    statusIn = 32'h0000_0002; epcIn = 32'hFFFF_FFFC; eretReq = 1;
    push_ev(cyc + 1, 1, 5'd12, 6'd0, 32'h0000_0000, 1, 32'hFFFF_FFFC);
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL b2b_eret_timeout: got %b want 1", ok);
    else n_pass++;
    eretReq = 0;
    settle_and_check_empty("b2b");
  endtask

  task automatic test_reset_mid;
    int c; bit ok;
    start_exc(5'h04, 32'h0040_0400, 1'b0, 32'h0000_0000, c);
    push_ev(c + 1, 1, 5'd14, 6'd0, 32'h0040_0400, 0, 32'h0);
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1;
    #1;
    n_total++;
    if ({cp0Write, busy, redirect, addrW, selW, din, redirectPc} !== '0)
      $display("FAIL midrst_outputs: got w=%b busy=%b r=%b a=%0d s=%0d d=%h pc=%h, want all 0",
               cp0Write, busy, redirect, addrW, selW, din, redirectPc);
    else
      n_pass++;
    excReq = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    @(posedge clk); #1;
    statusIn = 32'h0000_0003; epcIn = 32'h0040_0404; eretReq = 1;
    push_ev(cyc + 1, 1, 5'd12, 6'd0, 32'h0000_0001, 1, 32'h0040_0404);
    wait_idle(ok);
    n_total++;
    if (ok !== 1'b1) $display("FAIL midrst_timeout: got %b want 1", ok);
    else n_pass++;
    eretReq = 0;
    settle_and_check_empty("midrst");
  endtask

  initial begin
    test_reset();
    test_exc_noexl();
    test_exc_bd();
    test_exc_exl();
    test_eret();
    test_mtc0();
    test_mtc0_vs_exc();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
